// File: rtl/glitch_pkg.sv
// Shared constants for the glitch sequencer: FSM state encodings and the
// jitter LFSR seed/taps.
package glitch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ARMED  = 3'd1;
  localparam state_t ST_DELAY  = 3'd2;
  localparam state_t ST_GLITCH = 3'd3;
  localparam state_t ST_GAP    = 3'd4;

  // Jitter offset width: offsets span 0..15 cycles.
  localparam int JIT_W = 4;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/glitch_lfsr.sv
// Free-running 16-bit maximal LFSR that supplies the timing jitter offset.
// Only instantiated when GLITCH_JITTER_EN is defined.
module glitch_lfsr
  import glitch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [JIT_W-1:0] jitter
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign jitter = lfsr_reg[JIT_W-1:0];

endmodule

// File: rtl/glitch_sequencer.sv
// Power-glitch sequencer: after arm and a trigger rising edge, drops power for
// a programmed width, repeat times, separated by gaps. Optional GLITCH_JITTER_EN.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int DLY_W = 27,
  parameter int WID_W = 20,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             trigger,
  input  logic             abort,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [WID_W-1:0] cfg_width,
  input  logic [DLY_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_repeat,
  output logic             power,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] glitch_cnt
);

  // One shared down-counter times delay, glitch and gap phases.
  localparam int CNT_W = (DLY_W > WID_W) ? DLY_W : WID_W;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [DLY_W-1:0]   dly_reg, gap_reg;
  logic [WID_W-1:0]   wid_reg;
  logic [REP_W-1:0]   rep_reg;
  logic [REP_W-1:0]   glitch_cnt_reg;
  logic               trig_prev_reg;
  logic               power_reg;
  logic               done_reg, done_next;
  logic               load_cfg, cnt_clr, cnt_inc;

  logic               trig_edge;
  logic [JIT_W-1:0]   jit;
  logic [CNT_W-1:0]   wid_eff, delay_eff, gap_eff;
  logic [CNT_W:0]     delay_sum, gap_sum;
  logic [REP_W-1:0]   rep_eff;
  logic               last_glitch;

`ifdef GLITCH_JITTER_EN
  glitch_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .jitter (jit)
  );
`else
  assign jit = '0;
`endif

  assign trig_edge = trigger & ~trig_prev_reg;

  // Zero widths/gaps/repeats behave as one; jitter sums clamp instead of wrapping.
  assign wid_eff   = (wid_reg == '0) ? CNT_W'(1) : CNT_W'(wid_reg);
  assign delay_sum = (CNT_W+1)'(dly_reg) + (CNT_W+1)'(jit);
  assign gap_sum   = ((gap_reg == '0) ? (CNT_W+1)'(1) : (CNT_W+1)'(gap_reg)) + (CNT_W+1)'(jit);
  assign delay_eff = delay_sum[CNT_W] ? '1 : delay_sum[CNT_W-1:0];
  assign gap_eff   = gap_sum[CNT_W] ? '1 : gap_sum[CNT_W-1:0];
  assign rep_eff   = (rep_reg == '0) ? REP_W'(1) : rep_reg;
  assign last_glitch = (glitch_cnt_reg >= rep_eff);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_cfg   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    done_next  = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arm) begin
            state_next = ST_ARMED;
            load_cfg   = 1'b1;
            cnt_clr    = 1'b1;
          end
        end
        ST_ARMED: begin
          if (trig_edge) begin
            if (delay_eff == '0) begin
              state_next = ST_GLITCH;
              cnt_next   = wid_eff;
              cnt_inc    = 1'b1;
            end else begin
              state_next = ST_DELAY;
              cnt_next   = delay_eff;
            end
          end
        end
        ST_DELAY, ST_GAP: begin
          if (cnt_reg <= CNT_W'(1)) begin
            state_next = ST_GLITCH;
            cnt_next   = wid_eff;
            cnt_inc    = 1'b1;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        ST_GLITCH: begin
          if (cnt_reg <= CNT_W'(1)) begin
            if (last_glitch) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = ST_GAP;
              cnt_next   = gap_eff;
            end
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      dly_reg        <= '0;
      wid_reg        <= '0;
      gap_reg        <= '0;
      rep_reg        <= '0;
      glitch_cnt_reg <= '0;
      trig_prev_reg  <= 1'b0;
      power_reg      <= 1'b1;
      done_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      trig_prev_reg <= trigger;
      // Power is registered from the next state so the target supply never sees decode hazards.
      power_reg     <= (state_next != ST_GLITCH);
      done_reg      <= done_next;
      if (load_cfg) begin
        dly_reg <= cfg_delay;
        wid_reg <= cfg_width;
        gap_reg <= cfg_gap;
        rep_reg <= cfg_repeat;
      end
      if (cnt_clr) begin
        glitch_cnt_reg <= '0;
      end else if (cnt_inc) begin
        glitch_cnt_reg <= glitch_cnt_reg + REP_W'(1);
      end
    end
  end

  assign power      = power_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = done_reg;
  assign glitch_cnt = glitch_cnt_reg;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed testbench for glitch_sequencer; bit k of a capture mask is the
// cycle k after the trigger edge cycle T (bit 0 = T).
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst, arm, trigger, abort;
  logic [26:0] cfg_delay, cfg_gap;
  logic [19:0] cfg_width;
  logic [7:0]  cfg_repeat;
  logic        power, busy, done;
  logic [7:0]  glitch_cnt;

  int total = 0;
  int bad   = 0;

  glitch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .trigger    (trigger),
    .abort      (abort),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_gap    (cfg_gap),
    .cfg_repeat (cfg_repeat),
    .power      (power),
    .busy       (busy),
    .done       (done),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cfg(input int d, input int w, input int g, input int r);
    cfg_delay  = d[26:0];
    cfg_width  = w[19:0];
    cfg_gap    = g[26:0];
    cfg_repeat = r[7:0];
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic capture(input int n, input bit hold,
                         output logic [63:0] low_m, output logic [63:0] done_m);
    trigger = 1'b1;
    low_m   = '0;
    done_m  = '0;
    low_m[0]  = ~power;
    done_m[0] = done;
    for (int k = 1; k < n; k++) begin
      tick();
      if (k == 2 && !hold) trigger = 1'b0;
      low_m[k]  = ~power;
      done_m[k] = done;
    end
    if (!hold) trigger = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
    cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_repeat = '0;
    tick(); tick();
    total++; if (power !== 1'b1) begin bad++; $display("FAIL reset_power got=%b exp=1", power); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", glitch_cnt); end
    rst = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    $display("test_reset complete");
  endtask

  task automatic test_single();
    logic [63:0] lo, dn;
    arm_cfg(5, 3, 0, 1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_armed_busy got=%b exp=1", busy); end
    capture(20, 1'b0, lo, dn);
    total++; if (lo !== 64'h1C0) begin bad++; $display("FAIL single_low got=%h exp=%h", lo, 64'h1C0); end
    total++; if (dn !== 64'h200) begin bad++; $display("FAIL single_done got=%h exp=%h", dn, 64'h200); end
    total++; if (glitch_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", glitch_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    $display("test_single low=%h done=%h cnt=%0d", lo, dn, glitch_cnt);
  endtask

  task automatic test_repeat();
    logic [63:0] lo, dn;
    arm_cfg(0, 2, 4, 3);
    capture(24, 1'b0, lo, dn);
    total++; if (lo !== 64'h6186) begin bad++; $display("FAIL repeat_low got=%h exp=%h", lo, 64'h6186); end
    total++; if (dn !== 64'h8000) begin bad++; $display("FAIL repeat_done got=%h exp=%h", dn, 64'h8000); end
    total++; if (glitch_cnt !== 8'd3) begin bad++; $display("FAIL repeat_cnt got=%0d exp=3", glitch_cnt); end
    $display("test_repeat low=%h done=%h cnt=%0d", lo, dn, glitch_cnt);
  endtask

  task automatic test_zero_fields();
    logic [63:0] lo, dn;
    arm_cfg(2, 0, 0, 0);
    capture(12, 1'b0, lo, dn);
    total++; if (lo !== 64'h8) begin bad++; $display("FAIL zero_low got=%h exp=%h", lo, 64'h8); end
    total++; if (dn !== 64'h10) begin bad++; $display("FAIL zero_done got=%h exp=%h", dn, 64'h10); end
    total++; if (glitch_cnt !== 8'd1) begin bad++; $display("FAIL zero_cnt got=%0d exp=1", glitch_cnt); end
    $display("test_zero_fields low=%h done=%h cnt=%0d", lo, dn, glitch_cnt);
  endtask

  task automatic test_back_to_back();
    logic [63:0] lo, dn;
    tick(); tick(); tick();
    total++; if (glitch_cnt !== 8'd1) begin bad++; $display("FAIL b2b_hold got=%0d exp=1", glitch_cnt); end
    arm_cfg(1, 1, 0, 1);
    total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL b2b_clear got=%0d exp=0", glitch_cnt); end
    capture(10, 1'b0, lo, dn);
    total++; if (lo !== 64'h4) begin bad++; $display("FAIL b2b_low got=%h exp=%h", lo, 64'h4); end
    total++; if (dn !== 64'h8) begin bad++; $display("FAIL b2b_done got=%h exp=%h", dn, 64'h8); end
    $display("test_back_to_back low=%h done=%h", lo, dn);
  endtask

  task automatic test_abort();
    int ndone, nlow;
    arm_cfg(2, 10, 0, 1);
    trigger = 1'b1;
    tick(); tick(); tick();
    total++; if (power !== 1'b0) begin bad++; $display("FAIL abort_pre_power got=%b exp=0", power); end
    abort = 1'b1;
    trigger = 1'b0;
    tick();
    total++; if (power !== 1'b1) begin bad++; $display("FAIL abort_power got=%b exp=1", power); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    abort = 1'b0;
    ndone = (done === 1'b1) ? 1 : 0;
    nlow = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done === 1'b1) ndone++;
      if (power !== 1'b1) nlow++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", ndone); end
    total++; if (nlow !== 0) begin bad++; $display("FAIL abort_low got=%0d exp=0", nlow); end
    $display("test_abort done_pulses=%0d low_cycles=%0d", ndone, nlow);
  endtask

  task automatic test_trigger_held();
    logic [63:0] lo, dn;
    int nlow;
    arm_cfg(1, 2, 3, 1);
    capture(20, 1'b1, lo, dn);
    total++; if (lo !== 64'hC) begin bad++; $display("FAIL held_low got=%h exp=%h", lo, 64'hC); end
    total++; if (dn !== 64'h10) begin bad++; $display("FAIL held_done got=%h exp=%h", dn, 64'h10); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_rearm got=%b exp=0", busy); end
    arm_cfg(1, 2, 3, 1);
    nlow = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (power !== 1'b1) nlow++;
    end
    total++; if (nlow !== 0) begin bad++; $display("FAIL held_noedge_low got=%0d exp=0", nlow); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_noedge_busy got=%b exp=1", busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    trigger = 1'b0;
    tick();
    $display("test_trigger_held low=%h done=%h", lo, dn);
  endtask

  task automatic test_rst_mid_glitch();
    arm_cfg(1, 20, 0, 1);
    trigger = 1'b1;
    tick(); tick();
    total++; if (power !== 1'b0) begin bad++; $display("FAIL rstmid_pre_power got=%b exp=0", power); end
    #2 rst = 1'b1;
    #1;
    total++; if (power !== 1'b1) begin bad++; $display("FAIL rstmid_power got=%b exp=1", power); end
    total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", glitch_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    #1 rst = 1'b0;
    trigger = 1'b0;
    tick();
    total++; if (power !== 1'b1) begin bad++; $display("FAIL rstmid_after got=%b exp=1", power); end
    $display("test_rst_mid_glitch power=%b cnt=%0d", power, glitch_cnt);
  endtask

  task automatic test_latched_cfg();
    logic [63:0] lo, dn;
    arm_cfg(3, 2, 0, 1);
    cfg_delay = 27'd9; cfg_width = 20'd7; cfg_gap = 27'd5; cfg_repeat = 8'd5;
    tick();
    capture(20, 1'b0, lo, dn);
    total++; if (lo !== 64'h30) begin bad++; $display("FAIL latched_low got=%h exp=%h", lo, 64'h30); end
    total++; if (dn !== 64'h40) begin bad++; $display("FAIL latched_done got=%h exp=%h", dn, 64'h40); end
    total++; if (glitch_cnt !== 8'd1) begin bad++; $display("FAIL latched_cnt got=%0d exp=1", glitch_cnt); end
    $display("test_latched_cfg low=%h done=%h", lo, dn);
  endtask

  task automatic test_jitter();
    int off, first_off, guard;
    bit differ;
    differ = 1'b0;
    first_off = -1;
    for (int s = 0; s < 100; s++) begin
      arm_cfg(10, 1, 0, 1);
      trigger = 1'b1;
      off = 0;
      for (int k = 1; k < 40 && off == 0; k++) begin
        tick();
        if (k == 2) trigger = 1'b0;
        if (power === 1'b0) off = k;
      end
      trigger = 1'b0;
      total++;
      if (off < 11 || off > 26) begin
        bad++;
        $display("FAIL jitter_offset seq=%0d got=%0d exp=11..26", s, off);
      end
      if (first_off < 0) first_off = off;
      else if (off != first_off) differ = 1'b1;
      guard = 0;
      while (busy === 1'b1 && guard < 40) begin
        tick();
        guard++;
      end
      tick();
      $display("test_jitter seq=%0d offset=%0d", s, off);
    end
    total++; if (differ !== 1'b1) begin bad++; $display("FAIL jitter_spread got=all_equal exp=varied"); end
  endtask

  initial begin
    test_reset();
`ifdef GLITCH_JITTER_EN
    test_jitter();
`else
    test_single();
    test_repeat();
    test_zero_fields();
    test_back_to_back();
    test_abort();
    test_trigger_held();
    test_rst_mid_glitch();
    test_latched_cfg();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
